// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters.
// Paces grants on tx_busy plus a guard gap, and aborts if tx_busy never rises.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           cur_id,
  output logic                 arb_busy,
  output logic                 err_pulse
);

  localparam int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [2:0]       r_cur_id;
  logic             r_arb_busy;
  logic             r_err_pulse;

  logic             w_grant_any;
  logic [ID_W-1:0]  w_grant_id;
  logic [7:0]       w_grant_data;
  logic [ID_W-1:0]  w_next_ptr;
  logic             w_accept;
  logic             w_timeout;
  logic             w_gap_done;

  // First valid requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    logic [ID_W:0] idx;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    idx         = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (ID_W+1)'(r_rr_ptr) + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!w_grant_any && req_valid[idx[ID_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_grant_id == ID_W'(k)) begin
        w_grant_data = req_data[8*k +: 8];
      end
    end
  end

  assign w_next_ptr = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
  assign w_accept   = (r_state == S_IDLE) && !tx_busy && w_grant_any;
  // The tx_start cycle counts as the first cycle of the busy timeout.
  assign w_timeout  = (32'(r_cnt) + 32'd1) >= BUSY_TIMEOUT;
  assign w_gap_done = (32'(r_cnt) + 32'd1) >= GAP_CYCLES;

  // Ready is held low while rst_n is asserted so reset clears every output.
  assign req_ready = (w_accept && rst_n) ? (NUM_REQ'(1) << w_grant_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_cur_id    <= '0;
      r_arb_busy  <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_err_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_grant_data;
            r_cur_id   <= 3'(w_grant_id);
            r_rr_ptr   <= w_next_ptr;
            r_tx_start <= 1'b1;
            r_arb_busy <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= CNT_W'(1);
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            r_err_pulse <= 1'b1;
            r_arb_busy  <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_arb_busy <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign cur_id    = r_cur_id;
  assign arb_busy  = r_arb_busy;
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected bytes/ids,
// a negedge monitor pops and compares on every tx_start.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned GAP     = 16;
  localparam int unsigned BT      = 64;
  localparam int unsigned FRAME   = 20;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [2:0]           cur_id;
  logic                 arb_busy;
  logic                 err_pulse;

  logic model_en;
  logic model_busy;
  int   model_cnt;
  logic ext_busy;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  int   cyc = 0;
  int   start_cnt = 0;
  int   last_start = 0;
  int   last_fall = 0;
  int   err_cnt = 0;
  int   last_err = 0;
  int   ready_cnt[NUM_REQ];

  always #5 clk = ~clk;

  assign tx_busy = model_busy | ext_busy;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .cur_id(cur_id), .arb_busy(arb_busy), .err_pulse(err_pulse)
  );

  // uart_tx stand-in: busy for FRAME cycles starting the edge after tx_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_en && tx_start && !model_busy) begin
      model_busy <= 1'b1;
      model_cnt  <= FRAME;
    end else if (model_busy) begin
      if (model_cnt == 1) model_busy <= 1'b0;
      model_cnt <= model_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    logic [7:0] hold_val;
    logic hold_active, hold_bad, seen_busy, prev_busy, have_fall;
    hold_val = '0; hold_active = 0; hold_bad = 0; seen_busy = 0; prev_busy = 0; have_fall = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) ready_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold_active = 0; have_fall = 0; seen_busy = 0; prev_busy = 0;
      end else begin
        if (req_ready != '0) begin
          for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) ready_cnt[i]++;
          chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
          chk("ready_only_idle", 32'(arb_busy), 32'd0);
        end
        if (tx_start) begin
          start_cnt++;
          last_start = cyc;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_unexpected_start: got data 0x%0h id %0d, expected no start", tx_data, cur_id);
          end else begin
            e = exp_q.pop_front();
            chk("sb_tx_data", 32'(tx_data), 32'(e.data));
            chk("sb_cur_id", 32'(cur_id), 32'(e.id));
          end
          if (have_fall) chk("gap_after_busy", 32'((cyc - 1 - last_fall) >= int'(GAP)), 32'd1);
          have_fall = 0;
          hold_val = tx_data; hold_active = 1; hold_bad = 0; seen_busy = 0;
        end else if (hold_active && tx_data !== hold_val) begin
          hold_bad = 1;
        end
        if (hold_active && tx_busy) seen_busy = 1;
        if (prev_busy && !tx_busy && hold_active && seen_busy) begin
          chk("tx_data_held", 32'(hold_bad ? ~hold_val : tx_data), 32'(hold_val));
          hold_active = 0;
          last_fall = cyc;
          have_fall = 1;
        end
        if (err_pulse) begin
          err_cnt++;
          last_err = cyc;
        end
        prev_busy = tx_busy;
      end
    end
  end

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({pfx, "_tx_start"},  32'(tx_start),  32'd0);
    chk({pfx, "_tx_data"},   32'(tx_data),   32'd0);
    chk({pfx, "_cur_id"},    32'(cur_id),    32'd0);
    chk({pfx, "_arb_busy"},  32'(arb_busy),  32'd0);
    chk({pfx, "_err_pulse"}, 32'(err_pulse), 32'd0);
  endtask

  task automatic wait_start(input int s0, input string name);
    int n = 0;
    while (start_cnt == s0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (start_cnt == s0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: got no tx_start in 500 cycles, expected one", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((arb_busy || tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(arb_busy | tx_busy), 32'd0);
  endtask

  task automatic send(input logic [NUM_REQ-1:0] mask, input logic [7:0] d, input int id,
                      input string name);
    int s0;
    exp_q.push_back('{data: d, id: 3'(id)});
    s0 = start_cnt;
    req_valid = mask;
    wait_start(s0, name);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int s0, e0, n, snap[NUM_REQ];
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    ext_busy  = 1'b0;
    model_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // Single requester
    req_data[7:0] = 8'hA5;
    snap[0] = ready_cnt[0];
    exp_q.push_back('{data: 8'hA5, id: 3'd0});
    req_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    chk("single_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_busy", 32'(arb_busy), 32'd1);
    @(negedge clk);
    chk("single_start_one_cycle", 32'(tx_start), 32'd0);
    wait_idle("single");
    chk("single_ready_pulses", 32'(ready_cnt[0] - snap[0]), 32'd1);

    // Round-robin from a fresh pointer
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_q.push_back('{data: 8'h11, id: 3'd0});
    exp_q.push_back('{data: 8'h22, id: 3'd1});
    exp_q.push_back('{data: 8'h33, id: 3'd2});
    exp_q.push_back('{data: 8'h44, id: 3'd3});
    exp_q.push_back('{data: 8'h11, id: 3'd0});
    s0 = start_cnt;
    req_valid = '1;
    n = 0;
    while (start_cnt < s0 + 5 && n < 2000) begin @(negedge clk); n++; end
    chk("rr_five_grants", 32'(start_cnt - s0), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("rr");

    // Busy timeout: pointer now at 1
    model_en = 1'b0;
    req_data[15:8] = 8'h5A;
    e0 = err_cnt;
    send(4'b0010, 8'h5A, 1, "timeout_send");
    n = 0;
    while (err_cnt == e0 && n < int'(BT) + 20) begin @(negedge clk); n++; end
    chk("timeout_err_seen", 32'(err_cnt - e0), 32'd1);
    chk("timeout_latency", 32'(last_err - last_start), 32'(BT));
    @(negedge clk);
    chk("timeout_err_one_cycle", 32'(err_pulse), 32'd0);
    chk("timeout_back_idle", 32'(arb_busy), 32'd0);
    model_en = 1'b1;
    req_data[7:0]   = 8'hC3;
    req_data[23:16] = 8'h3C;
    send(4'b0101, 8'h3C, 2, "timeout_next");
    wait_idle("timeout");

    // Reset during WAIT_DONE: pointer at 3, grant requester 1 then abort it
    req_data[15:8] = 8'h96;
    send(4'b0010, 8'h96, 1, "rst_send");
    n = 0;
    while (!tx_busy && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("rst_in_frame", 32'(arb_busy & tx_busy), 32'd1);
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = '1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.push_back('{data: 8'h11, id: 3'd0});
    s0 = start_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_start(s0, "rst_first_grant");
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("rst");

    // Withdrawal: pointer at 1, requester 1 drops out before its turn
    for (int i = 0; i < int'(NUM_REQ); i++) snap[i] = ready_cnt[i];
    ext_busy = 1'b1;
    req_data[15:8]  = 8'hB1;
    req_data[31:24] = 8'hD3;
    req_valid = 4'b1010;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    exp_q.push_back('{data: 8'hD3, id: 3'd3});
    s0 = start_cnt;
    @(posedge clk); #1;
    ext_busy = 1'b0;
    wait_start(s0, "withdraw_grant");
    @(posedge clk); #1;
    req_valid = '0;
    chk("withdraw_no_ready1", 32'(ready_cnt[1] - snap[1]), 32'd0);
    chk("withdraw_ready3", 32'(ready_cnt[3] - snap[3]), 32'd1);
    wait_idle("withdraw");

    // External busy holds off requester 2
    for (int i = 0; i < int'(NUM_REQ); i++) snap[i] = ready_cnt[i];
    ext_busy = 1'b1;
    req_data[23:16] = 8'hE2;
    req_valid = 4'b0100;
    repeat (8) @(negedge clk);
    chk("ext_busy_no_ready", 32'(ready_cnt[2] - snap[2]), 32'd0);
    exp_q.push_back('{data: 8'hE2, id: 3'd2});
    s0 = start_cnt;
    @(posedge clk); #1;
    ext_busy = 1'b0;
    wait_start(s0, "ext_busy_grant");
    @(posedge clk); #1;
    req_valid = '0;
    chk("ext_busy_ready2", 32'(ready_cnt[2] - snap[2]), 32'd1);
    wait_idle("ext");

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("err_total", 32'(err_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
